flash_port_arbiter: RTL and testbench

- Shares the single external QSPI flash pin group (fsclk, fcen, fdo[3:0], fdoe, fdi[3:0]) between two transaction-level requesters.
- Requester 0 is the core's flash instruction/data reader. Requester 1 is the Wishbone-side flash programmer/reader.
- Sits between the flash masters and the pad ring. Registers pad outputs and inserts a chip-select guard interval on every ownership change.

---
 rtl/flash_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_flash_port_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/flash_port_arbiter.sv
// Two-requester QSPI pad arbiter: registered pads, chip-select guard between owners, preempt hint.
// Define FLASH_ARB_RR_EN to resolve ties toward the requester that did not own most recently.
module flash_port_arbiter #(
  parameter int GUARD_CYC = 2,
  parameter int MAX_HOLD  = 256
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic [1:0] preempt_o,
  input  logic       r0_sclk_i,
  input  logic       r1_sclk_i,
  input  logic       r0_cen_i,
  input  logic       r1_cen_i,
  input  logic [3:0] r0_do_i,
  input  logic [3:0] r1_do_i,
  input  logic       r0_doe_i,
  input  logic       r1_doe_i,
  input  logic [3:0] fdi_i,
  output logic [3:0] r_di_o,
  output logic       fsclk_o,
  output logic       fcen_o,
  output logic [3:0] fdo_o,
  output logic       fdoe_o,
  output logic       busy_o
);

  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MAX_HOLD);
  localparam logic [3:0]    GUARD_LOAD = 4'(GUARD_CYC - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GUARD} state_t;

  state_t        r_state;
  logic [3:0]    r_guard_cnt;
  logic [HW-1:0] r_hold;
  logic [1:0]    r_gnt;
  logic [1:0]    r_preempt;
  logic          r_fsclk;
  logic          r_fcen;
  logic [3:0]    r_fdo;
  logic          r_fdoe;

  logic          w_pick_r1;
  logic          w_own1;
  logic          w_release;
  logic          w_other_req;
  logic [HW-1:0] w_hold_nxt;
  logic          w_preempt_hit;
  logic          w_own_sclk;
  logic          w_own_cen;
  logic [3:0]    w_own_do;
  logic          w_own_doe;

`ifdef FLASH_ARB_RR_EN
  logic r_last_owner;
  assign w_pick_r1 = req_i[1] & (~req_i[0] | ~r_last_owner);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_last_owner <= 1'b1;
    end else if (r_state == OWN0) begin
      r_last_owner <= 1'b0;
    end else if (r_state == OWN1) begin
      r_last_owner <= 1'b1;
    end
  end
`else
  assign w_pick_r1 = req_i[1] & ~req_i[0];
`endif

  assign w_own1      = (r_state == OWN1);
  assign w_own_sclk  = w_own1 ? r1_sclk_i : r0_sclk_i;
  assign w_own_cen   = w_own1 ? r1_cen_i  : r0_cen_i;
  assign w_own_do    = w_own1 ? r1_do_i   : r0_do_i;
  assign w_own_doe   = w_own1 ? r1_doe_i  : r0_doe_i;
  // Release only at a transaction boundary: request low while cen is already high.
  assign w_release   = ~(w_own1 ? req_i[1] : req_i[0]) & w_own_cen;
  assign w_other_req = w_own1 ? req_i[0] : req_i[1];
  assign w_hold_nxt  = (r_hold == HOLD_MAX) ? r_hold : r_hold + 1'b1;
  assign w_preempt_hit = (MAX_HOLD != 0) && (w_hold_nxt >= HOLD_MAX) && w_other_req;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= IDLE;
      r_guard_cnt <= '0;
      r_hold      <= '0;
      r_gnt       <= 2'b00;
      r_preempt   <= 2'b00;
      r_fsclk     <= 1'b0;
      r_fcen      <= 1'b1;
      r_fdo       <= 4'h0;
      r_fdoe      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, GUARD: begin
          r_fsclk   <= 1'b0;
          r_fcen    <= 1'b1;
          r_fdo     <= 4'h0;
          r_fdoe    <= 1'b0;
          r_preempt <= 2'b00;
          r_hold    <= '0;
          if (r_state == GUARD && r_guard_cnt != 4'd0) begin
            r_guard_cnt <= r_guard_cnt - 4'd1;
          end else if (req_i != 2'b00) begin
            r_state <= w_pick_r1 ? OWN1 : OWN0;
            r_gnt   <= w_pick_r1 ? 2'b10 : 2'b01;
          end else begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
          end
        end
        default: begin
          if (w_release) begin
            r_state     <= GUARD;
            r_guard_cnt <= GUARD_LOAD;
            r_gnt       <= 2'b00;
            r_preempt   <= 2'b00;
            r_hold      <= '0;
            r_fsclk     <= 1'b0;
            r_fcen      <= 1'b1;
            r_fdo       <= 4'h0;
            r_fdoe      <= 1'b0;
          end else begin
            r_hold    <= w_hold_nxt;
            r_preempt <= w_own1 ? {w_preempt_hit, 1'b0} : {1'b0, w_preempt_hit};
            r_fsclk   <= w_own_sclk;
            r_fcen    <= w_own_cen;
            r_fdo     <= w_own_do;
            r_fdoe    <= w_own_doe;
          end
        end
      endcase
    end
  end

  assign gnt_o     = r_gnt;
  assign preempt_o = r_preempt;
  assign fsclk_o   = r_fsclk;
  assign fcen_o    = r_fcen;
  assign fdo_o     = r_fdo;
  assign fdoe_o    = r_fdoe;
  assign busy_o    = (r_state != IDLE);
  assign r_di_o    = fdi_i;

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Directed bench for flash_port_arbiter (GUARD_CYC=2, MAX_HOLD=8): vector table plus corner sequences.
module tb_flash_port_arbiter;

  logic       wb_clk_i;
  logic       wb_rst_i;
  logic [1:0] req_i;
  logic [1:0] gnt_o;
  logic [1:0] preempt_o;
  logic       r0_sclk_i, r1_sclk_i;
  logic       r0_cen_i, r1_cen_i;
  logic [3:0] r0_do_i, r1_do_i;
  logic       r0_doe_i, r1_doe_i;
  logic [3:0] fdi_i;
  logic [3:0] r_di_o;
  logic       fsclk_o, fcen_o, fdoe_o, busy_o;
  logic [3:0] fdo_o;

  flash_port_arbiter #(.GUARD_CYC(2), .MAX_HOLD(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .preempt_o(preempt_o), .r0_sclk_i(r0_sclk_i), .r1_sclk_i(r1_sclk_i),
    .r0_cen_i(r0_cen_i), .r1_cen_i(r1_cen_i), .r0_do_i(r0_do_i), .r1_do_i(r1_do_i),
    .r0_doe_i(r0_doe_i), .r1_doe_i(r1_doe_i), .fdi_i(fdi_i), .r_di_o(r_di_o),
    .fsclk_o(fsclk_o), .fcen_o(fcen_o), .fdo_o(fdo_o), .fdoe_o(fdoe_o), .busy_o(busy_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [1:0] req;
    logic       c0;
    logic       c1;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] gnt;
    logic       fcen;
    logic [3:0] fdo;
    logic       busy;
  } vec_t;

  vec_t vecs[16];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [1:0] rr_exp[4];

  function automatic vec_t mk(input logic [1:0] rq, input logic c0, input logic c1,
                              input logic [3:0] d0, input logic [3:0] d1, input logic [1:0] g,
                              input logic fc, input logic [3:0] fd, input logic bz);
    vec_t v;
    v.req = rq; v.c0 = c0; v.c1 = c1; v.d0 = d0; v.d1 = d1;
    v.gnt = g; v.fcen = fc; v.fdo = fd; v.busy = bz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (gnt_o == 2'b00 && n < 8) begin
      tick();
      n++;
    end
  endtask

  initial begin
    wb_rst_i = 1'b1;
    req_i = 2'b00;
    r0_sclk_i = 1'b0; r1_sclk_i = 1'b0;
    r0_cen_i = 1'b1;  r1_cen_i = 1'b1;
    r0_do_i = 4'h0;   r1_do_i = 4'h0;
    r0_doe_i = 1'b0;  r1_doe_i = 1'b0;
    fdi_i = 4'h0;

    //         req    c0    c1    d0    d1    gnt    fcen  fdo   busy
    vecs[0]  = mk(2'b00, 1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 1'b0);
    vecs[1]  = mk(2'b10, 1'b1, 1'b1, 4'h0, 4'h0, 2'b10, 1'b1, 4'h0, 1'b1);
    vecs[2]  = mk(2'b10, 1'b1, 1'b0, 4'h0, 4'hA, 2'b10, 1'b0, 4'hA, 1'b1);
    vecs[3]  = mk(2'b00, 1'b1, 1'b0, 4'h0, 4'h5, 2'b10, 1'b0, 4'h5, 1'b1);
    vecs[4]  = mk(2'b00, 1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 1'b1);
    vecs[5]  = mk(2'b00, 1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 1'b1);
    vecs[6]  = mk(2'b00, 1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 1'b0);
    vecs[7]  = mk(2'b11, 1'b1, 1'b1, 4'h0, 4'h0, 2'b01, 1'b1, 4'h0, 1'b1);
    vecs[8]  = mk(2'b11, 1'b0, 1'b1, 4'h3, 4'h0, 2'b01, 1'b0, 4'h3, 1'b1);
    vecs[9]  = mk(2'b10, 1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 1'b1);
    vecs[10] = mk(2'b10, 1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 1'b1);
    vecs[11] = mk(2'b10, 1'b1, 1'b1, 4'h0, 4'h0, 2'b10, 1'b1, 4'h0, 1'b1);
    vecs[12] = mk(2'b10, 1'b1, 1'b0, 4'h0, 4'hC, 2'b10, 1'b0, 4'hC, 1'b1);
    vecs[13] = mk(2'b00, 1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 1'b1);
    vecs[14] = mk(2'b00, 1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 1'b1);
    vecs[15] = mk(2'b00, 1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 1'b0);

`ifdef FLASH_ARB_RR_EN
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
`else
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b01; rr_exp[2] = 2'b01; rr_exp[3] = 2'b01;
`endif

    #12;
    chk("rst_gnt", 8'(gnt_o), 8'h00);
    chk("rst_fcen", 8'(fcen_o), 8'h01);
    chk("rst_busy", 8'(busy_o), 8'h00);
    chk("rst_preempt", 8'(preempt_o), 8'h00);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    for (int i = 0; i < 16; i++) begin
      req_i = vecs[i].req;
      r0_cen_i = vecs[i].c0; r1_cen_i = vecs[i].c1;
      r0_do_i = vecs[i].d0;  r1_do_i = vecs[i].d1;
      tick();
      chk($sformatf("vec%0d_gnt", i), 8'(gnt_o), 8'(vecs[i].gnt));
      chk($sformatf("vec%0d_fcen", i), 8'(fcen_o), 8'(vecs[i].fcen));
      chk($sformatf("vec%0d_fdo", i), 8'(fdo_o), 8'(vecs[i].fdo));
      chk($sformatf("vec%0d_busy", i), 8'(busy_o), 8'(vecs[i].busy));
    end

    fdi_i = 4'h9;
    #1;
    chk("di_bcast", 8'(r_di_o), 8'h09);

    // Request drop while cen is low must not release the grant.
    req_i = 2'b01; r0_cen_i = 1'b1;
    tick();
    r0_cen_i = 1'b0;
    tick();
    req_i = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("middrop_hold%0d", k), 8'(gnt_o), 8'h01);
    end
    r0_cen_i = 1'b1;
    tick();
    chk("middrop_rel_gnt", 8'(gnt_o), 8'h00);
    chk("middrop_rel_busy", 8'(busy_o), 8'h01);
    tick(); tick();
    chk("middrop_idle", 8'(busy_o), 8'h00);

    // Preempt hint appears once hold count reaches 8 with R1 waiting.
    req_i = 2'b01;
    tick();
    chk("pre_own0", 8'(gnt_o), 8'h01);
    r0_cen_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) req_i = 2'b11;
      chk($sformatf("pre_k%0d", k), 8'(preempt_o), (k >= 8) ? 8'h01 : 8'h00);
    end
    chk("pre_no_revoke", 8'(gnt_o), 8'h01);
    req_i = 2'b10; r0_cen_i = 1'b1;
    tick();
    chk("pre_clear", 8'(preempt_o), 8'h00);
    chk("pre_rel_gnt", 8'(gnt_o), 8'h00);
    tick(); tick();
    chk("pre_next_gnt", 8'(gnt_o), 8'h10 >> 3);
    chk("pre_next_preempt", 8'(preempt_o), 8'h00);
    req_i = 2'b00;
    tick(); tick(); tick();

    // Tie resolution across back-to-back transactions, from a fresh reset.
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    #2;
    wb_rst_i = 1'b0;
    req_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt();
      chk($sformatf("tie_gnt%0d", k), 8'(gnt_o), 8'(rr_exp[k]));
      if (gnt_o == 2'b10) begin
        r1_cen_i = 1'b0; tick();
        r1_cen_i = 1'b1; req_i = 2'b01; tick();
      end else begin
        r0_cen_i = 1'b0; tick();
        r0_cen_i = 1'b1; req_i = 2'b10; tick();
      end
      req_i = 2'b11;
    end
    req_i = 2'b00;
    tick(); tick(); tick(); tick();
    chk("tie_idle", 8'(busy_o), 8'h00);

    // Asynchronous reset in the middle of an R0 transaction.
    req_i = 2'b01;
    tick();
    r0_cen_i = 1'b0; r0_sclk_i = 1'b1; r0_doe_i = 1'b1;
    tick();
    chk("ar_pre_fcen", 8'(fcen_o), 8'h00);
    chk("ar_pre_fsclk", 8'(fsclk_o), 8'h01);
    chk("ar_pre_fdoe", 8'(fdoe_o), 8'h01);
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("ar_fcen", 8'(fcen_o), 8'h01);
    chk("ar_fsclk", 8'(fsclk_o), 8'h00);
    chk("ar_fdoe", 8'(fdoe_o), 8'h00);
    chk("ar_gnt", 8'(gnt_o), 8'h00);
    chk("ar_busy", 8'(busy_o), 8'h00);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    tick();
    chk("ar_regrant", 8'(gnt_o), 8'h01);
    chk("ar_regrant_fcen", 8'(fcen_o), 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
